// File: rtl/dzcpd_sched_pkg.sv
// Shared types for the DZCPD phase scheduler: FSM states, channel count and
// the "next enabled channel" search used when stepping through the scan mask.
package dzcpd_sched_pkg;

  localparam int CH       = 3;
  localparam int CH_W     = 2;
  localparam int SETTLE_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic            found;
    logic [CH_W-1:0] idx;
  } ch_pick_t;

  // Lowest enabled channel strictly above cur, or the lowest overall when from_start.
  function automatic ch_pick_t pick_channel(input logic [CH-1:0]   mask,
                                            input logic [CH_W-1:0] cur,
                                            input logic            from_start);
    ch_pick_t pick;
    pick = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (CH_W'(i) > cur))) begin
        pick.found = 1'b1;
        pick.idx   = CH_W'(i);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dzcpd_settle_timer.sv
// Loadable down counter timing the settle interval after each channel switch.
// A load value of zero is clamped to one so every channel settles at least one cycle.
module dzcpd_settle_timer
  import dzcpd_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                en,
  output logic                expire
);

  logic [SETTLE_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= (load_val == '0) ? SETTLE_W'(1) : load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - SETTLE_W'(1);
    end
  end

  assign expire = (count_reg == SETTLE_W'(1));

endmodule

// File: rtl/dzcpd_phase_scheduler.sv
// Time-multiplexes one DZCPD measurement chain over Va/Vb/Vc and banks the results.
// Optional amplitude check (amp_min port, res_fault) enabled by DZCPD_SCHED_AMP_CHECK_EN.
module dzcpd_phase_scheduler
  import dzcpd_sched_pkg::*;
#(
  parameter int M = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [CH-1:0]       ch_mask,
  input  logic [SETTLE_W-1:0] settle_cyc,
  input  logic [7:0]          k_cfg,
  input  logic [15:0]         meas_freq,
  input  logic signed [M-1:0] meas_amp,
  input  logic [15:0]         meas_phase,
  output logic [CH_W-1:0]     sel,
  output logic [7:0]          k,
  output logic                meas_clr,
  output logic                busy,
  output logic                done,
  output logic [16*CH-1:0]    res_freq,
  output logic [M*CH-1:0]     res_amp,
  output logic [16*CH-1:0]    res_phase,
  output logic [CH-1:0]       res_valid,
  output logic [CH-1:0]       res_fault
`ifdef DZCPD_SCHED_AMP_CHECK_EN
  ,
  input  logic [M-1:0]        amp_min
`endif
);

  state_t              state_reg, state_next;
  logic [CH_W-1:0]     sel_reg, sel_next;
  logic [7:0]          k_reg;
  logic [CH-1:0]       mask_reg;
  logic [SETTLE_W-1:0] settle_reg;
  logic                accept;
  logic                capture;
  logic                tmr_load;
  logic                tmr_expire;
  logic                amp_low;
  ch_pick_t            pick;

  dzcpd_settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (settle_reg),
    .en       (state_reg == ST_SETTLE),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      sel_reg    <= '0;
      k_reg      <= '0;
      mask_reg   <= '0;
      settle_reg <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      if (accept) begin
        mask_reg   <= ch_mask;
        settle_reg <= settle_cyc;
        k_reg      <= k_cfg;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    accept     = 1'b0;
    capture    = 1'b0;
    tmr_load   = 1'b0;
    pick       = '0;
    case (state_reg)
      ST_IDLE: begin
        if (start && !abort) begin
          accept = 1'b1;
          pick   = pick_channel(ch_mask, '0, 1'b1);
          if (pick.found) begin
            sel_next   = pick.idx;
            state_next = ST_SELECT;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_SELECT: begin
        tmr_load   = 1'b1;
        state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (tmr_expire) begin
          state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        capture = 1'b1;
        pick    = pick_channel(mask_reg, sel_reg, 1'b0);
        if (pick.found) begin
          sel_next   = pick.idx;
          state_next = ST_SELECT;
        end else begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    // Abort terminates the scan outright: no capture, no channel step, no done.
    if (abort && (state_reg != ST_IDLE)) begin
      state_next = ST_IDLE;
      sel_next   = sel_reg;
      capture    = 1'b0;
      tmr_load   = 1'b0;
    end
  end

`ifdef DZCPD_SCHED_AMP_CHECK_EN
  logic [M-1:0] amp_abs;

  // Magnitude saturates so the most negative code does not wrap back to itself.
  always_comb begin
    amp_abs = meas_amp;
    if (meas_amp[M-1]) begin
      if (meas_amp == {1'b1, {(M-1){1'b0}}}) begin
        amp_abs = {1'b0, {(M-1){1'b1}}};
      end else begin
        amp_abs = -meas_amp;
      end
    end
  end

  assign amp_low = (amp_abs < amp_min);
`else
  assign amp_low = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_slot
      logic [15:0]  freq_reg;
      logic [15:0]  phase_reg;
      logic [M-1:0] amp_reg;
      logic         valid_reg;
      logic         hit;

      assign hit = capture && (sel_reg == CH_W'(gi));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          freq_reg  <= '0;
          phase_reg <= '0;
          amp_reg   <= '0;
          valid_reg <= 1'b0;
        end else if (accept) begin
          valid_reg <= 1'b0;
        end else if (hit) begin
          freq_reg  <= amp_low ? 16'd0 : meas_freq;
          phase_reg <= amp_low ? 16'd0 : meas_phase;
          amp_reg   <= meas_amp;
          valid_reg <= !amp_low;
        end
      end

`ifdef DZCPD_SCHED_AMP_CHECK_EN
      logic fault_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          fault_reg <= 1'b0;
        end else if (accept) begin
          fault_reg <= 1'b0;
        end else if (hit) begin
          fault_reg <= amp_low;
        end
      end

      assign res_fault[gi] = fault_reg;
`else
      assign res_fault[gi] = 1'b0;
`endif

      assign res_freq[gi*16 +: 16]  = freq_reg;
      assign res_phase[gi*16 +: 16] = phase_reg;
      assign res_amp[gi*M +: M]     = amp_reg;
      assign res_valid[gi]          = valid_reg;
    end
  endgenerate

  assign sel      = sel_reg;
  assign k        = k_reg;
  assign meas_clr = (state_reg == ST_SELECT);
  assign busy     = (state_reg != ST_IDLE);
  assign done     = (state_reg == ST_DONE);

endmodule

// File: tb/tb_dzcpd_phase_scheduler.sv
// Scoreboard bench for dzcpd_phase_scheduler: expectations are queued per scan,
// a monitor pops and compares on every done pulse.
module tb_dzcpd_phase_scheduler;

  localparam int M = 14;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [2:0]        ch_mask = '0;
  logic [23:0]       settle_cyc = '0;
  logic [7:0]        k_cfg = '0;
  logic [15:0]       meas_freq;
  logic signed [M-1:0] meas_amp;
  logic [15:0]       meas_phase;
  logic [1:0]        sel;
  logic [7:0]        k;
  logic              meas_clr;
  logic              busy;
  logic              done;
  logic [47:0]       res_freq;
  logic [3*M-1:0]    res_amp;
  logic [47:0]       res_phase;
  logic [2:0]        res_valid;
  logic [2:0]        res_fault;
`ifdef DZCPD_SCHED_AMP_CHECK_EN
  logic [M-1:0]      amp_min = 14'd100;
`endif

  logic [15:0]         freq_tab  [3];
  logic signed [M-1:0] amp_tab   [3];
  logic [15:0]         phase_tab [3];

  // Emulated DZCPD: outputs follow whichever phase the mux currently selects.
  assign meas_freq  = freq_tab[sel];
  assign meas_amp   = amp_tab[sel];
  assign meas_phase = phase_tab[sel];

  dzcpd_phase_scheduler #(.M(M)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .ch_mask    (ch_mask),
    .settle_cyc (settle_cyc),
    .k_cfg      (k_cfg),
    .meas_freq  (meas_freq),
    .meas_amp   (meas_amp),
    .meas_phase (meas_phase),
    .sel        (sel),
    .k          (k),
    .meas_clr   (meas_clr),
    .busy       (busy),
    .done       (done),
    .res_freq   (res_freq),
    .res_amp    (res_amp),
    .res_phase  (res_phase),
    .res_valid  (res_valid),
    .res_fault  (res_fault)
`ifdef DZCPD_SCHED_AMP_CHECK_EN
    ,
    .amp_min    (amp_min)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             lat;
    logic [2:0]     valid;
    logic [2:0]     fault;
    logic [47:0]    freq;
    logic [3*M-1:0] amp;
    logic [47:0]    phase;
    logic [7:0]     kv;
    int             clrs;
    logic [5:0]     seq;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int lat, input logic [2:0] valid, input logic [2:0] fault,
                          input logic [47:0] freq, input logic [3*M-1:0] amp,
                          input logic [47:0] phase, input logic [7:0] kv,
                          input int clrs, input logic [5:0] seq);
    exp_t e;
    e.lat = lat; e.valid = valid; e.fault = fault; e.freq = freq; e.amp = amp;
    e.phase = phase; e.kv = kv; e.clrs = clrs; e.seq = seq;
    q.push_back(e);
  endtask

  task automatic set_tables(input logic [15:0] f0, input logic [15:0] f1, input logic [15:0] f2,
                            input logic signed [M-1:0] a0, input logic signed [M-1:0] a1,
                            input logic signed [M-1:0] a2,
                            input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2);
    freq_tab[0] = f0;  freq_tab[1] = f1;  freq_tab[2] = f2;
    amp_tab[0] = a0;   amp_tab[1] = a1;   amp_tab[2] = a2;
    phase_tab[0] = p0; phase_tab[1] = p1; phase_tab[2] = p2;
  endtask

  // Returns at the falling edge inside the first cycle after the accepting edge.
  task automatic start_scan(input logic [2:0] mask, input logic [23:0] st, input logic [7:0] kv);
    @(negedge clk);
    ch_mask = mask; settle_cyc = st; k_cfg = kv; start = 1'b1;
    $display("scan start mask=%b settle=%0d k=%0d", mask, st, kv);
    @(negedge clk);
    start = 1'b0; ch_mask = ~mask; settle_cyc = 24'd99; k_cfg = 8'hEE;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(q.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sel"}, 64'(sel), 64'd0);
    check({tag, "_k"}, 64'(k), 64'd0);
    check({tag, "_meas_clr"}, 64'(meas_clr), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_res_freq"}, 64'(res_freq), 64'd0);
    check({tag, "_res_amp"}, 64'(res_amp), 64'd0);
    check({tag, "_res_phase"}, 64'(res_phase), 64'd0);
    check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_res_fault"}, 64'(res_fault), 64'd0);
  endtask

  // Monitor: measures latency and meas_clr activity per scan, compares on done.
  initial begin : monitor
    int   t0 = 0;
    int   clr_n = 0;
    logic [5:0] seq = '0;
    logic busy_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_prev = 1'b0;
      end else begin
        if (busy && !busy_prev) begin
          t0 = cyc; clr_n = 0; seq = '0;
        end
        busy_prev = busy;
        if (meas_clr) begin
          clr_n++;
          seq = {seq[3:0], sel};
        end
        if (done) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
          end else begin
            e = q.pop_front();
            $display("done: lat=%0d valid=%b fault=%b freq=%h amp=%h phase=%h k=%0d clrs=%0d",
                     cyc - t0, res_valid, res_fault, res_freq, res_amp, res_phase, k, clr_n);
            check("latency", 64'(cyc - t0), 64'(e.lat));
            check("busy_at_done", 64'(busy), 64'd1);
            check("res_valid", 64'(res_valid), 64'(e.valid));
            check("res_fault", 64'(res_fault), 64'(e.fault));
            check("res_freq", 64'(res_freq), 64'(e.freq));
            check("res_amp", 64'(res_amp), 64'(e.amp));
            check("res_phase", 64'(res_phase), 64'(e.phase));
            check("k", 64'(k), 64'(e.kv));
            check("meas_clr_count", 64'(clr_n), 64'(e.clrs));
            check("sel_sequence", 64'(seq), 64'(e.seq));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    set_tables(16'h0, 16'h0, 16'h0, '0, '0, '0, 16'h0, 16'h0, 16'h0);
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Full scan: N=10, 3 channels -> 36 cycles from SELECT to DONE.
    set_tables(16'h1234, 16'h2345, 16'h3456, 14'sd100, -14'sd200, 14'sd300,
               16'h0AAA, 16'h0BBB, 16'h0CCC);
    push_exp(36, 3'b111, 3'b000, 48'h3456_2345_1234, {14'd300, -14'd200, 14'd100},
             48'h0CCC_0BBB_0AAA, 8'd4, 3, 6'b00_01_10);
    start_scan(3'b111, 24'd10, 8'd4);
    wait_drain(80);

    // Sparse mask, settle 0 clamps to 1; slot 1 keeps its previous contents.
    set_tables(16'h0101, 16'h0202, 16'h0303, 14'sd111, 14'sd222, 14'sd333,
               16'h1111, 16'h2222, 16'h3333);
    push_exp(6, 3'b101, 3'b000, 48'h0303_2345_0101, {14'd333, -14'd200, 14'd111},
             48'h3333_0BBB_1111, 8'd9, 2, 6'b00_00_10);
    start_scan(3'b101, 24'd0, 8'd9);
    wait_drain(40);

    // Empty mask: DONE right after accept, nothing captured.
    push_exp(0, 3'b000, 3'b000, 48'h0303_2345_0101, {14'd333, -14'd200, 14'd111},
             48'h3333_0BBB_1111, 8'd7, 0, 6'b0);
    start_scan(3'b000, 24'd5, 8'd7);
    wait_drain(20);

    // Abort during SETTLE of channel 1 (N=5: ch1 SETTLE spans cycles 9..13).
    set_tables(16'h0A0A, 16'h0B0B, 16'h0C0C, 14'sd500, 14'sd600, 14'sd700,
               16'h4A4A, 16'h4B4B, 16'h4C4C);
    start_scan(3'b111, 24'd5, 8'd3);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    $display("abort: busy=%b sel=%0d valid=%b", busy, sel, res_valid);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_sel", 64'(sel), 64'd1);
    repeat (5) @(negedge clk);
    check("abort_valid", 64'(res_valid), 64'b001);
    check("abort_freq0", 64'(res_freq[15:0]), 64'h0A0A);
    check("abort_phase0", 64'(res_phase[15:0]), 64'h4A4A);

    // start and abort together in IDLE: not accepted, valid bits untouched.
    @(negedge clk);
    ch_mask = 3'b111; settle_cyc = 24'd2; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    $display("start+abort: busy=%b valid=%b", busy, res_valid);
    check("start_abort_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("start_abort_valid", 64'(res_valid), 64'b001);
    check("start_abort_k", 64'(k), 64'd3);

    // Reset asserted mid-CAPTURE of channel 0 (N=2: CAPTURE is cycle 4).
    start_scan(3'b111, 24'd2, 8'd5);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    $display("reset mid-scan: busy=%b valid=%b k=%0d", busy, res_valid, k);
    check_all_zero("midreset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    set_tables(16'h5005, 16'h6006, 16'h7007, -14'sd1000, 14'sd2000, -14'sd3000,
               16'h5555, 16'h6666, 16'h7777);
    push_exp(9, 3'b111, 3'b000, 48'h7007_6006_5005, {-14'd3000, 14'd2000, -14'd1000},
             48'h7777_6666_5555, 8'd6, 3, 6'b00_01_10);
    start_scan(3'b111, 24'd1, 8'd6);
    wait_drain(40);

`ifdef DZCPD_SCHED_AMP_CHECK_EN
    // Vb below amp_min: faulted, freq/phase zeroed, amplitude kept.
    set_tables(16'h0F01, 16'h0F02, 16'h0F03, 14'sd150, -14'sd50, 14'sd120,
               16'h0E01, 16'h0E02, 16'h0E03);
    push_exp(9, 3'b101, 3'b010, 48'h0F03_0000_0F01, {14'd120, -14'd50, 14'd150},
             48'h0E03_0000_0E01, 8'd2, 3, 6'b00_01_10);
    start_scan(3'b111, 24'd1, 8'd2);
    wait_drain(40);
`endif

    repeat (5) @(negedge clk);
    check("queue_empty_at_end", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dzcpd_phase_scheduler.md
# dzcpd_phase_scheduler

Time-multiplexes one DZCPD measurement chain (amplitude, frequency, phase measurement) across the three phase voltages Va/Vb/Vc. The block drives the input-select mux and the `k` setting, clears the measurement chain on every channel switch, waits a programmable settling interval, then captures frequency/amplitude/phase into a per-channel result bank. It sits between the sequence-decomposer top level and the shared DZCPD instance, so one measurement datapath serves all three phases.

## Interface
- M, 14, sample/amplitude width (matches DZCPD)
- CH, 3, number of phase channels (fixed at 3; index width 2)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a scan; sampled only in IDLE
- abort  in  1  terminate scan; wins over start in the same cycle
- ch_mask  in  3  channel enable, bit0=Va, bit1=Vb, bit2=Vc; latched at start
- settle_cyc  in  24  settle cycles per channel; latched at start; 0 treated as 1
- k_cfg  in  8  divider setting for the frequency measurement; latched at start
- meas_freq  in  16  from DZCPD freq
- meas_amp  in  M signed  from DZCPD amp
- meas_phase  in  16  from DZCPD phase
- sel  out  2  input mux select to DZCPD Vin (0=Va, 1=Vb, 2=Vc)
- k  out  8  to DZCPD k
- meas_clr  out  1  one-cycle restart pulse to the measurement chain
- busy  out  1  high from the cycle after the accepted start until DONE inclusive
- done  out  1  one-cycle pulse at scan completion
- res_freq  out  48  packed {Vc,Vb,Va} 16-bit frequencies
- res_amp  out  3*M  packed signed amplitudes
- res_phase  out  48  packed phases
- res_valid  out  3  per-channel result valid
- res_fault  out  3  per-channel amplitude-check fault
- amp_min  in  M  minimum |amp|; port present only when DZCPD_SCHED_AMP_CHECK_EN is defined

## Operation
- States: IDLE, SELECT, SETTLE, CAPTURE, DONE.
- IDLE: on start && !abort → latch ch_mask, settle_cyc, k_cfg; clear res_valid and res_fault; load sel with the lowest enabled channel; go to SELECT. If ch_mask==0, go directly to DONE.
- SELECT (1 cycle): meas_clr=1; load the settle counter with max(settle_cyc,1); go to SETTLE.
- SETTLE: decrement each cycle; on count==1 go to CAPTURE.
- CAPTURE (1 cycle): register meas_* into slot sel and set res_valid[sel]. Pick the next higher enabled channel: if one exists, update sel and go to SELECT; otherwise go to DONE.
- DONE (1 cycle): done=1; go to IDLE.
- abort in any non-IDLE state → IDLE on the next edge; no done pulse; slots already captured keep their values and valid bits.
- start while busy is ignored. Mask, settle and k changes during a scan have no effect.
- sel and k hold their last values in IDLE.

## Timing
- Reset values: sel=0, k=0, meas_clr=0, busy=0, done=0, all res_*=0, state=IDLE.
- With start accepted at edge t, SELECT occupies cycle t+1.
- Each enabled channel costs N+2 cycles, where N=max(settle_cyc,1).
- done is high in cycle t+1+n·(N+2), where n = number of enabled channels.
- Results for a channel are visible the cycle after its CAPTURE edge.
- meas_clr is high exactly one cycle per channel.
- Asynchronous reset mid-scan forces all outputs to their reset values immediately.

## Configuration
- DZCPD_SCHED_AMP_CHECK_EN defined: the amp_min port exists. At CAPTURE, if |meas_amp| < amp_min, then res_fault[sel]=1, res_valid[sel]=0, and the freq and phase slots are stored as 0; amp is stored as measured. Absolute value saturates for the most negative input.
- Not defined: no amp_min port, res_fault is tied to 0, and every captured channel is valid.

## Structure
- Package dzcpd_sched_pkg: state encoding, CH=3, channel-index width, settle-counter width 24.
- Sub-module dzcpd_settle_timer: loadable 24-bit down counter with load/zero-clamp and an expire output.
- Result bank and FSM live in the top.

## Test plan
- Full scan: ch_mask=3'b111, settle_cyc=10, k_cfg=4, DZCPD outputs forced per sel → sel steps 0,1,2; meas_clr pulses 3 times; done in cycle t+37; res_valid=3'b111; slots hold per-channel values; k=4.
- Sparse mask: ch_mask=3'b101, settle_cyc=0 → channel 1 is skipped; N=1; done at t+7; res_valid=3'b101.
- Empty mask: ch_mask=0 → no meas_clr; done at t+1; res_valid=0.
- Abort: abort during SETTLE of channel 1 → IDLE next edge; no done; res_valid=3'b001; simultaneous start+abort in IDLE → stays IDLE.
- Reset mid-scan: drop rst during CAPTURE → all outputs zero immediately; a new start after release runs a clean scan.
- With DZCPD_SCHED_AMP_CHECK_EN, amp_min=100, meas_amp=-50 on Vb → res_fault=3'b010, res_valid=3'b101, Vb freq/phase slots=0, amp slot=-50.
